// File: rtl/jk_sr.sv
// jk_sr: positive-edge JK flip-flop built from a clocked SR core.
// The conversion stage turns J/K into S/R using the present state, so the
// SR core never sees S=R=1. Q_bar is the inverse of the single state bit,
// which means it can never equal Q.
module jk_sr (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_bar
);

  logic state_r;
  logic s_s;
  logic r_s;
  logic next_s;

  // SR core next-state rule. S=R=1 holds the state; the conversion stage
  // cannot produce it, but the core stays well defined if it appears.
  function automatic logic sr_next(input logic s, input logic r, input logic q);
    logic n;
    case ({s, r})
      2'b00:   n = q;
      2'b10:   n = 1'b1;
      2'b01:   n = 1'b0;
      default: n = q;
    endcase
    return n;
  endfunction

  // JK-to-SR conversion followed by the SR core next-state rule.
  always_comb begin
    s_s    = J & ~state_r;
    r_s    = K &  state_r;
    next_s = sr_next(s_s, r_s, state_r);
  end

  // State register. Reset clears it at once and wins over any clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= 1'b0;
    end else begin
      state_r <= next_s;
    end
  end

  assign Q     = state_r;
  assign Q_bar = ~state_r;

endmodule

// File: tb/tb_jk_sr.sv
// tb_jk_sr: directed plus randomized checks of jk_sr against a JK truth-table model.
module tb_jk_sr;

  logic clk;
  logic rst;
  logic J;
  logic K;
  logic Q;
  logic Q_bar;

  int tests;
  int failed;

  logic model_q;
  logic cmp_en;

  jk_sr dut (
    .clk   (clk),
    .rst   (rst),
    .J     (J),
    .K     (K),
    .Q     (Q),
    .Q_bar (Q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: JK truth table applied on each rising edge; reset clears at once.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q <= 1'b0;
    end else begin
      if (J && K)       model_q <= ~model_q;
      else if (J)       model_q <= 1'b1;
      else if (K)       model_q <= 1'b0;
      else              model_q <= model_q;
    end
  end

  // Compare process: outputs against the model once per cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("q_vs_model", Q, model_q);
      chk("qbar_vs_model", Q_bar, ~model_q);
    end
  end

  // Apply J/K on the falling edge, then sample after the next rising edge.
  task automatic tick(input logic j, input logic k, input logic exp_q, input string name);
    @(negedge clk);
    J = j;
    K = k;
    @(posedge clk);
    #1;
    chk(name, Q, exp_q);
    chk({name, "_bar"}, Q_bar, ~exp_q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests  = 0;
    failed = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    J      = 1'b0;
    K      = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk("reset_q", Q, 1'b0);
    chk("reset_qbar", Q_bar, 1'b1);

    // Release reset between edges.
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_hold", Q, 1'b0);

    // Reset / set / hold.
    tick(1'b0, 1'b1, 1'b0, "k_from_0");
    tick(1'b1, 1'b0, 1'b1, "j_set");
    tick(1'b0, 1'b0, 1'b1, "hold1_a");
    tick(1'b0, 1'b0, 1'b1, "hold1_b");
    tick(1'b0, 1'b0, 1'b1, "hold1_c");

    // Reset from set, then hold.
    tick(1'b0, 1'b1, 1'b0, "k_clear");
    tick(1'b0, 1'b0, 1'b0, "hold0");

    // Toggle for four edges: 1,0,1,0.
    tick(1'b1, 1'b1, 1'b1, "toggle_1");
    tick(1'b1, 1'b1, 1'b0, "toggle_2");
    tick(1'b1, 1'b1, 1'b1, "toggle_3");
    tick(1'b1, 1'b1, 1'b0, "toggle_4");

    // Async reset pulse mid-cycle from Q=1.
    tick(1'b1, 1'b0, 1'b1, "set_before_pulse");
    @(negedge clk);
    J = 1'b0;
    K = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_q", Q, 1'b0);
    chk("async_rst_qbar", Q_bar, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_async_hold", Q, 1'b0);

    // Glitch on J between edges has no effect.
    @(negedge clk);
    #1;
    J = 1'b1;
    #2;
    J = 1'b0;
    chk("glitch_no_comb", Q, 1'b0);
    @(posedge clk);
    #1;
    chk("glitch_ignored", Q, 1'b0);

    // Randomized J/K with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      J = 1'($urandom_range(0, 1));
      K = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        chk("rand_async_rst", Q, 1'b0);
        #1;
        rst = 1'b0;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
